// File: rtl/wb_burst_rd_master_if.sv
// Wishbone B3 bus bundle between the burst read master and the RAM slave.
// The master drives the request side; the slave answers with ack/err/rty and read data.
interface wb_burst_rd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [3:0]    sel;
  logic          we;
  logic [1:0]    bte;
  logic [2:0]    cti;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output adr, dat_w, sel, we, bte, cti, cyc, stb,
    input  ack, err, rty, dat_r
  );

  modport slave (
    input  adr, dat_w, sel, we, bte, cti, cyc, stb,
    output ack, err, rty, dat_r
  );
endinterface

// File: rtl/wb_burst_rd_master.sv
// Wishbone B3 burst read master: splits a (start address, word count) command into linear
// incrementing bursts and streams the words out of a FWFT FIFO. Optional stats: WB_BURST_RD_STATS_EN.
module wb_burst_rd_master #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AW-1:0]        cmd_adr_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  wb_burst_rd_master_if.master wbm,
  output logic [DW-1:0]        m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
`ifdef WB_BURST_RD_STATS_EN
  ,
  output logic [31:0]          stat_beats_o,
  output logic [15:0]          stat_errs_o
`endif
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_BURST,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             cyc_q, cyc_d;
  logic [2:0]       cti_q, cti_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [DW:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    fifo_free;
  logic [BW-1:0]    burst_beats;
  logic             space_ok;
  logic             bus_fault;
  logic             push;
  logic             pop;

  // Low address bits are ignored; words are always 4-byte aligned.
  logic unused_adr_bits;
  assign unused_adr_bits = ^cmd_adr_i[1:0];

  always_comb begin
    if (rem_q < LEN_W'(BURST_LEN)) burst_beats = rem_q[BW-1:0];
    else                           burst_beats = BW'(BURST_LEN);
  end

  // Space is reserved for a whole burst up front, so acks never find the FIFO full.
  assign fifo_free = CW'(FIFO_DEPTH) - fifo_cnt;
  assign space_ok  = fifo_free >= CW'(burst_beats);
  assign bus_fault = wbm.err | wbm.rty;
  assign push      = (state_q == S_BURST) & wbm.ack & ~bus_fault;
  assign pop       = m_valid_o & m_ready_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      adr_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            adr_d   = {cmd_adr_i[AW-1:2], 2'b00};
            rem_d   = cmd_len_i;
            state_d = S_WAIT_SPACE;
          end
        end
      end
      S_WAIT_SPACE: begin
        if (space_ok) begin
          cyc_d   = 1'b1;
          beats_d = burst_beats;
          cti_d   = (burst_beats == BW'(1)) ? CTI_CLASSIC : CTI_INCR;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (bus_fault) begin
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (wbm.ack) begin
          adr_d   = adr_q + AW'(4);
          rem_d   = rem_q - LEN_W'(1);
          beats_d = beats_q - BW'(1);
          if (beats_q == BW'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = S_GAP;
          end else if (beats_q == BW'(2)) begin
            cti_d = CTI_END;
          end
        end
      end
      // One cycle with cyc low so the slave can clear its burst tracking.
      S_GAP: begin
        state_d = (rem_q != '0) ? S_WAIT_SPACE : S_DONE;
      end
      S_DONE: begin
        if (fifo_cnt == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {(rem_q == LEN_W'(1)), wbm.dat_r};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  fifo_no_overflow: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
  fifo_no_underflow: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    !(pop && fifo_cnt == '0));

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  assign m_valid_o = (fifo_cnt != '0);
  assign m_data_o  = fifo_mem[rd_ptr][DW-1:0];
  assign m_last_o  = fifo_mem[rd_ptr][DW] & m_valid_o;

  assign wbm.adr   = adr_q;
  assign wbm.dat_w = '0;
  assign wbm.sel   = 4'hf;
  assign wbm.we    = 1'b0;
  assign wbm.bte   = 2'b00;
  assign wbm.cti   = cti_q;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;

`ifdef WB_BURST_RD_STATS_EN
  logic [31:0] stat_beats_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stat_beats_q <= '0;
      stat_errs_q  <= '0;
    end else begin
      if (push && stat_beats_q != '1) stat_beats_q <= stat_beats_q + 32'd1;
      if (err_d && stat_errs_q != '1) stat_errs_q  <= stat_errs_q + 16'd1;
    end
  end

  assign stat_beats_o = stat_beats_q;
  assign stat_errs_o  = stat_errs_q;
`endif

endmodule

// File: tb/tb_wb_burst_rd_master.sv
// Bench for wb_burst_rd_master: directed commands against a zero-wait RAM slave model,
// with bus beats and stream words checked by a scoreboard monitor.
module tb_wb_burst_rd_master;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BURST_LEN  = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_adr   = '0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             busy, done, err;
  logic [DW-1:0]    m_data;
  logic             m_valid, m_last;
  logic             m_ready   = 1'b0;
`ifdef WB_BURST_RD_STATS_EN
  logic [31:0]      stat_beats;
  logic [15:0]      stat_errs;
`endif

  wb_burst_rd_master_if #(.AW(AW), .DW(DW)) wb();

  wb_burst_rd_master #(
    .AW(AW), .DW(DW), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_adr_i   (cmd_adr),
    .cmd_len_i   (cmd_len),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .wbm         (wb.master),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready)
`ifdef WB_BURST_RD_STATS_EN
    ,
    .stat_beats_o(stat_beats),
    .stat_errs_o (stat_errs)
`endif
  );

  // RAM slave: contents are a fixed function of the address; fault injected on a chosen beat.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  int   fault_beat = 0;
  logic fault_rty  = 1'b0;
  int   beat_in_cyc;
  logic fault_now;

  assign fault_now = wb.cyc && wb.stb && (fault_beat != 0) && (beat_in_cyc + 1 == fault_beat);
  assign wb.ack    = wb.cyc & wb.stb & ~fault_now;
  assign wb.err    = fault_now & ~fault_rty;
  assign wb.rty    = fault_now & fault_rty;
  assign wb.dat_r  = ram_word(wb.adr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          beat_in_cyc <= 0;
    else if (!wb.cyc)                    beat_in_cyc <= 0;
    else if (wb.ack || wb.err || wb.rty) beat_in_cyc <= beat_in_cyc + 1;
  end

  typedef struct packed { logic [AW-1:0] adr; logic [2:0] cti; } bus_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } word_t;
  bus_t  exp_bus[$];
  word_t exp_stream[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0, err_seen = 0, bursts = 0, acks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] got);
    checks++;
    errors++;
    $display("FAIL %s got=%0h exp=nothing", name, got);
  endtask

  // Expected bus beats and stream words for one command; fault is the 1-based beat that errors.
  task automatic expect_cmd(input logic [AW-1:0] adr, input int len, input int fault);
    logic [AW-1:0] a;
    int rem, k, b;
    bus_t eb;
    word_t ew;
    a = {adr[AW-1:2], 2'b00};
    rem = len;
    k = 0;
    while (rem > 0) begin
      b = (rem < BURST_LEN) ? rem : BURST_LEN;
      for (int j = 0; j < b; j++) begin
        eb.adr = a;
        eb.cti = (b == 1) ? 3'b000 : ((j == b - 1) ? 3'b111 : 3'b010);
        exp_bus.push_back(eb);
        k++;
        if (k == fault) return;
        ew.data = ram_word(a);
        ew.last = (rem == 1);
        exp_stream.push_back(ew);
        a = a + 32'd4;
        rem--;
      end
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] adr, input int len);
    int budget;
    budget = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_adr   = adr;
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || m_valid || exp_stream.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, n < budget, 1);
    repeat (3) @(negedge clk);
    check({name, "_bus_drained"}, exp_bus.size(), 0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin
    int   low_run;
    logic prev_cyc;
    bus_t eb;
    word_t ew;
    low_run  = 1;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cyc = 1'b0;
        low_run  = 1;
        continue;
      end
      if (wb.cyc && !prev_cyc) begin
        bursts++;
        check("cyc_gap", low_run >= 1, 1);
      end
      if (wb.cyc) low_run = 0;
      else        low_run++;
      prev_cyc = wb.cyc;
      if (wb.cyc && wb.stb && (wb.ack || wb.err || wb.rty)) begin
        if (wb.ack) acks++;
        if (exp_bus.size() == 0) unexpected("bus_beat", wb.adr);
        else begin
          eb = exp_bus.pop_front();
          check("bus_adr", wb.adr, eb.adr);
          check("bus_cti", wb.cti, eb.cti);
        end
      end
      if (m_valid && m_ready) begin
        if (exp_stream.size() == 0) unexpected("stream_word", m_data);
        else begin
          ew = exp_stream.pop_front();
          check("stream_data", m_data, ew.data);
          check("stream_last", m_last, ew.last);
        end
      end
      if (done) begin
        done_seen++;
        check("busy_at_done", busy, 0);
      end
      if (err) begin
        err_seen++;
        check("done_at_err", done, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b0, a0, budget;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", wb.cyc, 0);
    check("rst_stb", wb.stb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_cti", wb.cti, 3'b000);
    check("rst_adr", wb.adr, 32'h0);
    check("tie_sel", wb.sel, 4'hf);
    check("tie_we_bte_dat", {wb.we, wb.bte, wb.dat_w}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", cmd_ready, 1);
    m_ready = 1'b1;

    // Single 4-beat burst.
    d0 = done_seen; b0 = bursts;
    expect_cmd(32'h100, 4, 0);
    send_cmd(32'h100, 4);
    wait_idle("t1", 200);
    check("t1_done", done_seen - d0, 1);
    check("t1_bursts", bursts - b0, 1);

    // 10 words: bursts of 4, 4, 2.
    d0 = done_seen; b0 = bursts;
    expect_cmd(32'h200, 10, 0);
    send_cmd(32'h200, 10);
    wait_idle("t2", 300);
    check("t2_done", done_seen - d0, 1);
    check("t2_bursts", bursts - b0, 3);

    // One word: classic cycle.
    d0 = done_seen; b0 = bursts;
    expect_cmd(32'h40, 1, 0);
    send_cmd(32'h40, 1);
    wait_idle("t3a", 100);
    check("t3a_done", done_seen - d0, 1);
    check("t3a_bursts", bursts - b0, 1);

    // Zero words: done one cycle after accept, no bus cycle.
    d0 = done_seen; b0 = bursts;
    send_cmd(32'h80, 0);
    check("t3b_done_pulse", done, 1);
    check("t3b_cyc", wb.cyc, 0);
    check("t3b_busy", busy, 0);
    @(posedge clk); #1;
    check("t3b_done_clear", done, 0);
    repeat (4) @(negedge clk);
    check("t3b_done_count", done_seen - d0, 1);
    check("t3b_bursts", bursts - b0, 0);

    // Stalled stream: 16 words fetched, then master waits with cyc low.
    d0 = done_seen; b0 = bursts; a0 = acks;
    m_ready = 1'b0;
    expect_cmd(32'h1000, 24, 0);
    send_cmd(32'h1000, 24);
    repeat (80) @(negedge clk);
    check("t4_acks_stalled", acks - a0, 16);
    check("t4_cyc_stalled", wb.cyc, 0);
    check("t4_busy_stalled", busy, 1);
    check("t4_valid_stalled", m_valid, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle("t4", 400);
    check("t4_acks", acks - a0, 24);
    check("t4_done", done_seen - d0, 1);
    check("t4_bursts", bursts - b0, 6);

    // Error on beat 3 of the first burst.
    d0 = done_seen; e0 = err_seen;
    fault_beat = 3; fault_rty = 1'b0;
    expect_cmd(32'h2000, 8, 3);
    send_cmd(32'h2000, 8);
    wait_idle("t5", 200);
    fault_beat = 0;
    check("t5_err", err_seen - e0, 1);
    check("t5_no_done", done_seen - d0, 0);

    d0 = done_seen;
    expect_cmd(32'h2100, 3, 0);
    send_cmd(32'h2100, 3);
    wait_idle("t5_next", 200);
    check("t5_next_done", done_seen - d0, 1);

    // Retry on the first beat is an error too.
    d0 = done_seen; e0 = err_seen;
    fault_beat = 1; fault_rty = 1'b1;
    expect_cmd(32'h3000, 2, 1);
    send_cmd(32'h3000, 2);
    wait_idle("t5_rty", 200);
    fault_beat = 0; fault_rty = 1'b0;
    check("t5_rty_err", err_seen - e0, 1);
    check("t5_rty_no_done", done_seen - d0, 0);

    // Unaligned start near the top of the address space wraps to 0.
    d0 = done_seen;
    expect_cmd(32'hFFFF_FFFA, 3, 0);
    send_cmd(32'hFFFF_FFFA, 3);
    wait_idle("wrap", 200);
    check("wrap_done", done_seen - d0, 1);

    // Reset mid-burst.
    expect_cmd(32'h4000, 8, 0);
    send_cmd(32'h4000, 8);
    budget = 0;
    @(negedge clk);
    while (!(wb.cyc && wb.ack) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("t6_burst_started", budget < 50, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_cyc", wb.cyc, 0);
    check("t6_stb", wb.stb, 0);
    check("t6_m_valid", m_valid, 0);
    check("t6_busy", busy, 0);
    exp_bus.delete();
    exp_stream.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_fifo_empty", m_valid, 0);
    d0 = done_seen;
    expect_cmd(32'h5000, 2, 0);
    send_cmd(32'h5000, 2);
    wait_idle("t6_next", 200);
    check("t6_next_done", done_seen - d0, 1);
`ifdef WB_BURST_RD_STATS_EN
    check("stat_beats", stat_beats, 2);
    check("stat_errs", stat_errs, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_rd_master.md
Name: wb_burst_rd_master

Overview:
- Wishbone B3 read master that sits directly upstream of the on-chip Wishbone RAM slave.
- Accepts a read command (start byte address, word count) and splits it into linear incrementing bursts of up to BURST_LEN beats.
- Buffers the returned words in an internal first-word-fall-through (FWFT) FIFO and presents them on a valid/ready stream.
- Lets accelerators pull large RAM regions without hand-driving Wishbone cycles.

Parameters:
AW, 32, Wishbone address width
DW, 32, Wishbone data width; fixed 32 (4-byte words)
BURST_LEN, 4, max beats per burst; power of 2, range 2..16
FIFO_DEPTH, 16, FIFO entries; power of 2, >= BURST_LEN
LEN_W, 16, width of the command word count

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_adr_i  in  AW  start byte address; bits[1:0] ignored
cmd_len_i  in  LEN_W  number of 32-bit words to read
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse: command completed without error
err_o  out  1  one-cycle pulse: command aborted on wbm_err_i/wbm_rty_i
wbm_adr_o  out  AW  Wishbone address
wbm_dat_o  out  DW  tied 0
wbm_sel_o  out  4  tied 4'hf
wbm_we_o  out  1  tied 0
wbm_bte_o  out  2  tied 2'b00 (linear)
wbm_cti_o  out  3  cycle type
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_ack_i  in  1  Wishbone acknowledge
wbm_err_i  in  1  Wishbone error
wbm_rty_i  in  1  Wishbone retry; treated as error
wbm_dat_i  in  DW  read data
m_data_o  out  DW  stream data
m_valid_o  out  1  stream valid
m_last_o  out  1  marks the final word of a successful command
m_ready_i  in  1  stream ready

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - State IDLE; FIFO emptied.
  - cyc, stb, busy, done, err and m_valid are 0; cti = 3'b000; wbm_adr_o = 0.
  - Assertion mid-burst drops the cycle immediately.
- States:
  - IDLE
    - cmd_ready_o = 1.
    - On accept with len == 0: pulse done_o the next cycle, stay in IDLE, no bus cycle.
    - On accept with len > 0: latch word address and remaining count, go to WAIT_SPACE.
  - WAIT_SPACE
    - beats = min(remaining, BURST_LEN).
    - When FIFO free entries >= beats, assert cyc and stb, go to BURST.
    - The reservation guarantees the FIFO never overflows. Pops during a burst only add space.
  - BURST
    - beats == 1: cti = 3'b000 (classic).
    - beats > 1: cti = 3'b010 on every beat except the last, which uses 3'b111.
    - Each wbm_ack_i pushes wbm_dat_i into the FIFO, registers wbm_adr_o += 4, and decrements the beat and remaining counters.
    - cti switches to 3'b111 on the cycle after the ack that leaves one beat outstanding.
    - After the last ack: cyc and stb drop the next cycle, go to GAP.
  - GAP
    - Exactly one idle cycle with cyc = 0. This lets the slave clear its burst tracking.
    - Go to WAIT_SPACE if remaining > 0, else DONE.
  - DONE
    - Wait until the FIFO is empty, then pulse done_o and go to IDLE.
- Error handling:
  - wbm_err_i or wbm_rty_i during BURST: data is not pushed; cyc and stb drop the next cycle.
  - err_o pulses once, and the state returns to IDLE directly (no DONE).
  - Words already in the FIFO remain deliverable; m_last_o is never asserted for the aborted command.
- Addressing:
  - wbm_adr_o[1:0] is always 0.
  - Address is AW-bit modular and wraps past the top without flagging.
- FIFO / stream:
  - FWFT: m_valid_o rises the cycle after the ack that writes an empty FIFO.
  - Simultaneous push and pop keeps the count unchanged.
  - Pop on m_valid_o & m_ready_i.
  - m_last_o is stored per entry; set on the word whose push made remaining reach 0.
- busy_o is 1 in every state except IDLE.

Optional Feature:
- Macro: WB_BURST_RD_STATS_EN.
- Defined:
  - Adds output stat_beats_o[31:0], counting every accepted ack (data beat) since reset; saturates at 32'hFFFF_FFFF.
  - Adds output stat_errs_o[15:0], counting err_o pulses; saturates.
  - Both clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. adr=0x100, len=4, BURST_LEN=4, RAM pre-filled, m_ready=1 -> one burst with cti 010,010,010,111; adr 0x100..0x10C; four stream words, m_last on the 4th; one done_o pulse; busy_o drops with done.
2. adr=0x200, len=10 -> bursts of 4,4,2 at 0x200, 0x210, 0x220, each followed by one idle cycle with cyc=0; 10 words in order; m_last only on word 10.
3. len=1 -> single classic cycle with cti=000; len=0 -> done_o pulse one cycle after accept, cyc never asserted.
4. FIFO_DEPTH=16, m_ready=0, len=24 -> exactly 16 words fetched, then the master waits in WAIT_SPACE with cyc=0; raising m_ready resumes and delivers all 24 words.
5. Slave asserts wbm_err_i on beat 3 of a 4-beat burst within len=8 -> cyc drops the next cycle, err_o pulses once, 2 words delivered without m_last, no done_o; a following command completes normally.
6. Reset pulled low mid-burst -> cyc, stb, m_valid and busy go to 0 asynchronously; after release, cmd_ready_o=1 and the FIFO is empty.
